// File: rtl/piso_pkg.sv
// Shared types and constants for the PISO shift register.
// Holds the FSM state encoding and width defaults.
package piso_pkg;

   localparam int DEF_WIDTH = 8;
   localparam int MIN_WIDTH = 2;
   localparam int MAX_WIDTH = 32;

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_t;

   // Counter width able to hold 0..w
   function automatic int cnt_w(input int w);
      return $clog2(w + 1);
   endfunction

endpackage

// File: rtl/piso_shift_reg_if.sv
// Load / serial-out bundle for the PISO shift register.
// master = word producer and bit consumer, slave = serializer.
interface piso_shift_reg_if #(
   parameter int WIDTH = 8
);

   logic             load_valid;
   logic             load_ready;
   logic [WIDTH-1:0] din;
   logic             shift_en;
   logic             sout;
   logic             sout_valid;
   logic             busy;
   logic             done;

   modport master (
      output load_valid,
      output din,
      output shift_en,
      input  load_ready,
      input  sout,
      input  sout_valid,
      input  busy,
      input  done
   );

   modport slave (
      input  load_valid,
      input  din,
      input  shift_en,
      output load_ready,
      output sout,
      output sout_valid,
      output busy,
      output done
   );

endinterface

// File: rtl/piso_bit_counter.sv
// Bit position counter for the serializer.
// Counts 0..WIDTH-1 and saturates; last flags the final bit.
module piso_bit_counter
   import piso_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   localparam int CW = cnt_w(WIDTH)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          clr,
   input  logic          inc,
   output logic [CW-1:0] count,
   output logic          last
);

   logic [CW-1:0] r_count;

   assign last  = (r_count == CW'(WIDTH - 1));
   assign count = r_count;

   // Clear wins over increment; never advance past the last bit
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_count <= '0;
      end else if (clr) begin
         r_count <= '0;
      end else if (inc && !last) begin
         r_count <= r_count + CW'(1);
      end
   end

endmodule

// File: rtl/piso_shift_reg.sv
// Parallel-in serial-out shift register with load handshake.
// Two-state FSM; supports back-to-back words without a gap.
module piso_shift_reg
   import piso_pkg::*;
#(
   parameter int WIDTH     = DEF_WIDTH,
   parameter bit MSB_FIRST = 1'b1,
   localparam int CW = cnt_w(WIDTH)
) (
   input  logic             clk,
   input  logic             rst,
   piso_shift_reg_if.slave  bus
);

   state_t           r_state;
   state_t           w_state_nxt;
   logic [WIDTH-1:0] r_sreg;
   logic [WIDTH-1:0] w_sreg_nxt;
   logic             r_done;
   logic             w_done_nxt;

   logic             w_ready;
   logic             w_load;
   logic             w_consume;
   logic             w_last;
   logic             w_clr;
   logic             w_inc;
   logic             w_bit;
   logic [CW-1:0]    w_count;

   // Handshake and bit-consumption qualifiers
   assign w_consume = (r_state == SHIFT) && bus.shift_en;
   assign w_ready   = (r_state == IDLE) || (w_consume && w_last);
   assign w_load    = bus.load_valid && w_ready;

   // Restart the count on a new word or when a word ends
   assign w_clr = w_load || (w_consume && w_last);
   assign w_inc = w_consume && !w_last;

   piso_bit_counter #(
      .WIDTH (WIDTH)
   ) u_cnt (
      .clk   (clk),
      .rst   (rst),
      .clr   (w_clr),
      .inc   (w_inc),
      .count (w_count),
      .last  (w_last)
   );

   // Current serial bit depends on shift direction
   assign w_bit = MSB_FIRST ? r_sreg[WIDTH-1] : r_sreg[0];

   assign bus.load_ready = w_ready;
   assign bus.busy       = (r_state == SHIFT);
   assign bus.sout_valid = (r_state == SHIFT);
   assign bus.sout       = (r_state == SHIFT) && w_bit;
   assign bus.done       = r_done;

   // Next-state, next shift contents and done pulse
   always_comb begin
      w_state_nxt = r_state;
      w_sreg_nxt  = r_sreg;
      w_done_nxt  = 1'b0;
      unique case (r_state)
         IDLE: begin
            if (w_load) begin
               w_state_nxt = SHIFT;
               w_sreg_nxt  = bus.din;
            end
         end
         SHIFT: begin
            if (w_consume) begin
               if (MSB_FIRST) begin
                  w_sreg_nxt = {r_sreg[WIDTH-2:0], 1'b0};
               end else begin
                  w_sreg_nxt = {1'b0, r_sreg[WIDTH-1:1]};
               end
               if (w_last) begin
                  w_done_nxt = 1'b1;
                  if (w_load) begin
                     w_sreg_nxt = bus.din;
                  end else begin
                     w_state_nxt = IDLE;
                  end
               end
            end
         end
         default: begin
            w_state_nxt = IDLE;
         end
      endcase
   end

   // State, shift register and done register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= IDLE;
         r_sreg  <= '0;
         r_done  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_sreg  <= w_sreg_nxt;
         r_done  <= w_done_nxt;
      end
   end

   // The counter must stay within the word
   a_cnt_range : assert property (
      @(posedge clk) disable iff (rst)
      w_count <= CW'(WIDTH - 1)
   );

endmodule

// File: tb/tb_piso_shift_reg.sv
// Directed self-checking bench for piso_shift_reg.
// Two instances: MSB-first (m) and LSB-first (l).
module tb_piso_shift_reg;

   logic clk;
   logic rst;
   int   checks;
   int   errors;

   piso_shift_reg_if #(.WIDTH(8)) m_if ();
   piso_shift_reg_if #(.WIDTH(8)) l_if ();

   piso_shift_reg #(
      .WIDTH     (8),
      .MSB_FIRST (1'b1)
   ) u_m (
      .clk (clk),
      .rst (rst),
      .bus (m_if)
   );

   piso_shift_reg #(
      .WIDTH     (8),
      .MSB_FIRST (1'b0)
   ) u_l (
      .clk (clk),
      .rst (rst),
      .bus (l_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag,
                      input logic [15:0] obs,
                      input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   initial begin
      logic [7:0]  w;
      logic [15:0] p;
      checks = 0;
      errors = 0;
      rst = 1'b1;
      m_if.load_valid = 1'b0;
      m_if.din        = '0;
      m_if.shift_en   = 1'b0;
      l_if.load_valid = 1'b0;
      l_if.din        = '0;
      l_if.shift_en   = 1'b0;

      // Reset state
      tick();
      tick();
      chk("rst_busy", 16'(m_if.busy), 16'h0);
      chk("rst_sout", 16'(m_if.sout), 16'h0);
      chk("rst_vld", 16'(m_if.sout_valid), 16'h0);
      chk("rst_done", 16'(m_if.done), 16'h0);
      rst = 1'b0;
      m_if.shift_en = 1'b1;
      tick();
      chk("idle_rdy", 16'(m_if.load_ready), 16'h1);
      chk("idle_sout", 16'(m_if.sout), 16'h0);
      chk("idle_busy", 16'(m_if.busy), 16'h0);

      // MSB first, 8'h1E, shift_en held
      w = 8'h1E;
      m_if.din = w;
      m_if.load_valid = 1'b1;
      tick();
      m_if.load_valid = 1'b0;
      chk("t1_rdy_c1", 16'(m_if.load_ready), 16'h0);
      for (int i = 0; i < 8; i++) begin
         chk("t1_sout", 16'(m_if.sout), 16'(w[7-i]));
         chk("t1_vld", 16'(m_if.sout_valid), 16'h1);
         chk("t1_done", 16'(m_if.done), 16'h0);
         tick();
      end
      chk("t1_done9", 16'(m_if.done), 16'h1);
      chk("t1_vld9", 16'(m_if.sout_valid), 16'h0);
      chk("t1_rdy9", 16'(m_if.load_ready), 16'h1);
      tick();
      chk("t1_done10", 16'(m_if.done), 16'h0);

      // LSB first, 8'h1E
      l_if.din = 8'h1E;
      l_if.shift_en = 1'b1;
      l_if.load_valid = 1'b1;
      tick();
      l_if.load_valid = 1'b0;
      p = 16'b0111_1000;
      for (int i = 0; i < 8; i++) begin
         chk("t2_sout", 16'(l_if.sout), 16'(p[7-i]));
         chk("t2_vld", 16'(l_if.sout_valid), 16'h1);
         tick();
      end
      chk("t2_vld9", 16'(l_if.sout_valid), 16'h0);
      chk("t2_done9", 16'(l_if.done), 16'h1);
      l_if.shift_en = 1'b0;

      // 8'hA5 with shift_en toggling, each bit held 2 cycles
      w = 8'hA5;
      m_if.din = w;
      m_if.shift_en = 1'b1;
      m_if.load_valid = 1'b1;
      tick();
      m_if.load_valid = 1'b0;
      for (int c = 1; c <= 16; c++) begin
         chk("t3_sout", 16'(m_if.sout), 16'(w[7-((c-1)/2)]));
         chk("t3_done", 16'(m_if.done), 16'h0);
         m_if.shift_en = (c % 2 == 0);
         tick();
      end
      chk("t3_done17", 16'(m_if.done), 16'h1);
      chk("t3_busy17", 16'(m_if.busy), 16'h0);
      m_if.shift_en = 1'b1;
      tick();

      // Back-to-back: 8'hF0 then 8'h0F with load_valid held
      m_if.din = 8'hF0;
      m_if.load_valid = 1'b1;
      tick();
      m_if.din = 8'h0F;
      p = 16'hF00F;
      for (int c = 1; c <= 16; c++) begin
         chk("t4_sout", 16'(m_if.sout), 16'(p[16-c]));
         chk("t4_vld", 16'(m_if.sout_valid), 16'h1);
         chk("t4_done", 16'(m_if.done), 16'(c == 9));
         if (c == 9) m_if.load_valid = 1'b0;
         tick();
      end
      chk("t4_done17", 16'(m_if.done), 16'h1);
      chk("t4_vld17", 16'(m_if.sout_valid), 16'h0);
      tick();

      // Reset after 3 bits of 8'hFF
      m_if.din = 8'hFF;
      m_if.load_valid = 1'b1;
      tick();
      m_if.load_valid = 1'b0;
      tick();
      tick();
      tick();
      chk("t5_pre_sout", 16'(m_if.sout), 16'h1);
      rst = 1'b1;
      #1;
      chk("t5_sout", 16'(m_if.sout), 16'h0);
      chk("t5_vld", 16'(m_if.sout_valid), 16'h0);
      chk("t5_busy", 16'(m_if.busy), 16'h0);
      tick();
      rst = 1'b0;
      chk("t5_rdy", 16'(m_if.load_ready), 16'h1);
      chk("t5_nodone", 16'(m_if.done), 16'h0);
      w = 8'h81;
      m_if.din = w;
      m_if.load_valid = 1'b1;
      tick();
      m_if.load_valid = 1'b0;
      for (int i = 0; i < 8; i++) begin
         chk("t5_sout81", 16'(m_if.sout), 16'(w[7-i]));
         chk("t5_done81", 16'(m_if.done), 16'h0);
         tick();
      end
      chk("t5_done9", 16'(m_if.done), 16'h1);
      tick();

      // 8'h55 offered mid-word of 8'hAA is ignored
      w = 8'hAA;
      m_if.din = w;
      m_if.load_valid = 1'b1;
      tick();
      m_if.load_valid = 1'b0;
      for (int c = 1; c <= 8; c++) begin
         chk("t6_sout", 16'(m_if.sout), 16'(w[8-c]));
         if (c == 2) begin
            m_if.din = 8'h55;
            m_if.load_valid = 1'b1;
         end
         if (c == 8) m_if.load_valid = 1'b0;
         tick();
      end
      chk("t6_done9", 16'(m_if.done), 16'h1);
      chk("t6_vld9", 16'(m_if.sout_valid), 16'h0);
      tick();
      chk("t6_busy10", 16'(m_if.busy), 16'h0);
      chk("t6_sout10", 16'(m_if.sout), 16'h0);
      chk("t6_done10", 16'(m_if.done), 16'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/piso_shift_reg.md
PISO_SHIFT_REG -- requirements
Module: piso_shift_reg

Interface
REQ-001 Parameter WIDTH, default 8: parallel word width in bits; legal range 2..32.
REQ-002 Parameter MSB_FIRST, default 1: 1 sends bit WIDTH-1 first; 0 sends bit 0 first.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 load_valid  input  1  parallel word offered on din.
REQ-006 load_ready  output  1  block can accept a word this cycle.
REQ-007 din  input  WIDTH  parallel data word.
REQ-008 shift_en  input  1  bit-rate enable; consumes the current serial bit when high.
REQ-009 sout  output  1  serial data bit.
REQ-010 sout_valid  output  1  sout carries a valid data bit.
REQ-011 busy  output  1  word in progress (state SHIFT).
REQ-012 done  output  1  one-cycle pulse after the last bit of a word is consumed.

Function
REQ-013 The FSM SHALL have exactly two states: IDLE and SHIFT.
REQ-014 A load SHALL be accepted on a rising edge where load_valid && load_ready; din is captured into the shift register and the bit counter is cleared.
REQ-015 load_ready SHALL be 1 in IDLE, and in SHIFT only when the last bit is current and shift_en=1; otherwise 0.
REQ-016 Accepting a load SHALL move the FSM to SHIFT; the first bit SHALL appear on sout with sout_valid=1 in the cycle after acceptance.
REQ-017 In SHIFT, a cycle with shift_en=1 SHALL consume the current bit; the next bit appears on sout the following cycle.
REQ-018 In SHIFT, a cycle with shift_en=0 SHALL hold sout, the shift register, and the counter unchanged.
REQ-019 After WIDTH consumed bits with no simultaneous load, the FSM SHALL return to IDLE, and sout_valid SHALL fall in the next cycle.
REQ-020 done SHALL pulse high for exactly one cycle, in the cycle after the last bit is consumed, including on back-to-back loads.
REQ-021 Back-to-back: if a load is accepted in the same cycle as the last-bit consumption, the FSM SHALL stay in SHIFT, and the new word's first bit SHALL follow with no idle cycle.
REQ-022 load_valid while load_ready=0 SHALL be ignored, with din not sampled.
REQ-023 In IDLE, sout SHALL be 0, sout_valid 0, and busy 0; shift_en in IDLE SHALL have no effect.
REQ-024 The bit counter SHALL be $clog2(WIDTH+1) bits wide, count 0..WIDTH-1, and never wrap past WIDTH-1.
REQ-025 busy SHALL equal (state==SHIFT), and sout_valid SHALL equal busy.

Reset
REQ-026 When rst=1, the block SHALL immediately force state IDLE, shift register 0, counter 0, and sout, sout_valid, busy and done to 0.
REQ-027 Reset mid-word SHALL abandon the word with no done pulse, and load_ready SHALL be 1 in the first cycle after rst deasserts.

Structure
REQ-028 Shared package piso_pkg SHALL hold the state enum (IDLE, SHIFT) and the default WIDTH constant.
REQ-029 The bit counter SHALL be a sub-module piso_bit_counter with inputs clr, inc and rst, and outputs count and last.
REQ-030 All other logic SHALL be in piso_shift_reg, using one registered always block plus combinational next-state logic.

Verification
REQ-031 WIDTH=8, MSB_FIRST=1, shift_en=1 held, load 8'h1E -> sout 0,0,0,1,1,1,1,0 on cycles 1-8 after acceptance; done=1 on cycle 9.
REQ-032 MSB_FIRST=0, load 8'h1E, shift_en=1 held -> sout 0,1,1,1,1,0,0,0; sout_valid high for exactly 8 cycles.
REQ-033 load 8'hA5 with shift_en toggling 1,0,1,0... -> each bit held 2 cycles, order 1,0,1,0,0,1,0,1; done 17 cycles after acceptance.
REQ-034 Back-to-back: load 8'hF0, then load_valid held with 8'h0F -> 16 contiguous valid bits 1111000000001111; done pulses twice, 8 cycles apart.
REQ-035 Assert rst after 3 bits of 8'hFF -> sout, sout_valid and busy are 0 immediately; no done; a subsequent load of 8'h81 serializes correctly.
REQ-036 load_valid with 8'h55 presented mid-word of 8'hAA -> ignored; only 8'hAA is transmitted, then IDLE.
